// File: rtl/ble_hec_tx_sequencer.sv
// ble_hec_tx_sequencer
//
// Sequencer for the Bluetooth TX header path (bit FIFO + HEC generator core).
// Takes one packet header at a time from the link layer, gates the header
// bits into the core write port, then opens the core FIFO read enable to
// drain the header through the HEC. It counts the header+HEC bits the core
// emits and reports done, or a timeout if the core stalls. The UAP/DCI seed
// is latched when a packet is accepted so the core sees a stable seed for
// the whole packet.
//
// Optional feature (compile-time macro BLE_HEC_SEQ_LEN_CHECK_EN):
//   When defined, the core's own bit count (core_num_after_hec) is compared
//   with HDR_BITS+HEC_BITS when the packet completes. A mismatch sets a
//   sticky length error that is reported through timeout_err. When the macro
//   is undefined, core_num_after_hec is ignored.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low reset
//   start               one-cycle packet request, only honoured in IDLE
//   abort               synchronous abort back to IDLE, highest priority
//   uap_dci_cfg[7:0]    seed, sampled when a start is accepted
//   in_valid, in_data   upstream header bit stream
//   in_ready            sequencer accepts a header bit this cycle
//   core_valid_in       core write strobe
//   core_data_in        core write data bit
//   core_enable         core FIFO read enable
//   core_uap_dci[7:0]   latched seed to the core
//   core_finished       core FIFO drained
//   core_valid_out      core output bit valid
//   core_data_out       core output bit
//   core_num_after_hec  core bit count (length check feature only)
//   out_valid, out_data forwarded core output bit
//   busy                any state other than IDLE
//   done                one-cycle pulse on packet completion
//   timeout_err         sticky error, cleared by the next accepted start
//   out_count[8:0]      bits forwarded in the current packet (saturating)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// FILL  | accepting header bits into the core FIFO
// DRAIN | core read enable on, waiting for core_finished
// FLUSH | read enable off, collecting the remaining HEC bits
// DONE  | one-cycle completion pulse
// ERR   | one-cycle timeout state, no done pulse

module ble_hec_tx_sequencer #(
    parameter int HDR_BITS = 10,
    parameter int HEC_BITS = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  uap_dci_cfg,
    input  logic        in_valid,
    input  logic        in_data,
    output logic        in_ready,
    output logic        core_valid_in,
    output logic        core_data_in,
    output logic        core_enable,
    output logic [7:0]  core_uap_dci,
    input  logic        core_finished,
    input  logic        core_valid_out,
    input  logic        core_data_out,
    input  logic [13:0] core_num_after_hec,
    output logic        out_valid,
    output logic        out_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [8:0]  out_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] TOTAL_BITS = 9'(HDR_BITS + HEC_BITS);
    localparam logic [7:0] WR_LAST    = 8'(HDR_BITS - 1);
    localparam logic [9:0] TMO_LIMIT  = 10'(TIMEOUT);
    localparam logic [8:0] OUT_MAX    = 9'd511;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wr_cnt;
    logic [9:0] tmo_cnt;
    logic       tmo_err;

    logic       accept_start;
    logic       wr_accept;
    logic       fwd;
    logic       pkt_complete;
    logic       tmo_hit;

    assign accept_start = (state == S_IDLE) && start && !abort;
    assign pkt_complete = (out_count == TOTAL_BITS);
    assign tmo_hit      = (tmo_cnt == TMO_LIMIT);
    assign wr_accept    = in_valid && in_ready;

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        core_valid_in = 1'b0;
        core_data_in  = 1'b0;
        fwd           = 1'b0;
        out_valid     = 1'b0;
        out_data      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                fwd      = 1'b1;
                if (in_valid && (wr_cnt == WR_LAST)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                fwd = 1'b1;
                // A packet whose bits are all out can never time out: it
                // goes through FLUSH and straight on to DONE.
                if (core_finished)  state_nxt = S_FLUSH;
                else if (tmo_hit)   state_nxt = pkt_complete ? S_FLUSH : S_ERR;
            end
            S_FLUSH: begin
                fwd = 1'b1;
                if (pkt_complete)   state_nxt = S_DONE;
                else if (tmo_hit)   state_nxt = S_ERR;
            end
            S_DONE: begin
                fwd       = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort) state_nxt = S_IDLE;

        core_valid_in = in_valid && in_ready;
        core_data_in  = in_data && in_ready;
        out_valid     = core_valid_out && fwd;
        out_data      = core_data_out && fwd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            core_enable  <= 1'b0;
            core_uap_dci <= 8'h00;
            wr_cnt       <= 8'd0;
            tmo_cnt      <= 10'd0;
            out_count    <= 9'd0;
            tmo_err      <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Registered so the core sees read enable the cycle after the
            // last header bit is written, and loses it the cycle after
            // core_finished, abort or timeout.
            core_enable <= (state_nxt == S_DRAIN);

            if (accept_start) begin
                core_uap_dci <= uap_dci_cfg;
                wr_cnt       <= 8'd0;
                tmo_cnt      <= 10'd0;
                out_count    <= 9'd0;
                tmo_err      <= 1'b0;
            end else if (!abort) begin
                if ((state == S_FILL) && wr_accept)
                    wr_cnt <= wr_cnt + 8'd1;
                if (((state == S_DRAIN) || (state == S_FLUSH)) && !tmo_hit)
                    tmo_cnt <= tmo_cnt + 10'd1;
                if (fwd && core_valid_out && (out_count != OUT_MAX))
                    out_count <= out_count + 9'd1;
                if (state_nxt == S_ERR)
                    tmo_err <= 1'b1;
            end
        end
    end

`ifdef BLE_HEC_SEQ_LEN_CHECK_EN
    localparam logic [13:0] CORE_LEN = 14'(HDR_BITS + HEC_BITS);

    logic len_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err <= 1'b0;
        end else if (accept_start) begin
            len_err <= 1'b0;
        end else if ((state_nxt == S_DONE) && (state != S_DONE) &&
                     (core_num_after_hec != CORE_LEN)) begin
            len_err <= 1'b1;
        end
    end

    assign timeout_err = tmo_err || len_err;
`else
    logic unused_num_after_hec;
    assign unused_num_after_hec = ^core_num_after_hec;
    assign timeout_err          = tmo_err;
`endif

endmodule

// File: tb/tb_ble_hec_tx_sequencer.sv
module tb_ble_hec_tx_sequencer;

`ifdef BLE_HEC_SEQ_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  uap_dci_cfg;
    logic        in_valid;
    logic        in_data;
    logic        in_ready;
    logic        core_valid_in;
    logic        core_data_in;
    logic        core_enable;
    logic [7:0]  core_uap_dci;
    logic        core_finished;
    logic        core_valid_out;
    logic        core_data_out;
    logic [13:0] core_num_after_hec;
    logic        out_valid;
    logic        out_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [8:0]  out_count;

    always #5 clk = ~clk;

    ble_hec_tx_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .uap_dci_cfg        (uap_dci_cfg),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .core_valid_in      (core_valid_in),
        .core_data_in       (core_data_in),
        .core_enable        (core_enable),
        .core_uap_dci       (core_uap_dci),
        .core_finished      (core_finished),
        .core_valid_out     (core_valid_out),
        .core_data_out      (core_data_out),
        .core_num_after_hec (core_num_after_hec),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .out_count          (out_count)
    );

    typedef struct {
        logic [7:0] seed;
        logic [9:0] hdr;
        logic       toggle;
        logic       stall;
        logic       poke;
        logic       len17;
        int         exp_ready;
        int         exp_oc;
        int         exp_done;
        int         exp_en;
        logic       exp_tmo;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   n_ready = 0, n_acc = 0, n_en = 0, n_done = 0, n_wr = 0;
    int   last_acc_cyc = 0, first_en_cyc = 0;
    logic en_prev = 1'b0;

    // core model state
    logic       m_stall;
    logic [7:0] m_hec_sh;
    int         m_hdr_read;
    int         m_hec_sent;
    logic       fifo_q[$];
    logic       exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: sample everything just before the rising edge, then update
    // the core model after the edge, and return at the falling edge where
    // the caller drives the next inputs.
    task automatic tick();
        logic e;
        #1;
        cyc++;
        if (in_ready) n_ready++;
        if (in_ready && in_valid) begin
            n_acc++;
            last_acc_cyc = cyc;
        end
        if (core_valid_in) begin
            n_wr++;
            fifo_q.push_back(core_data_in);
        end
        if (core_enable) begin
            n_en++;
            if (!en_prev) first_en_cyc = cyc;
        end
        en_prev = core_enable;
        if (done) n_done++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_bit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_out_data", {31'd0, out_data}, {31'd0, e});
            end
        end
        @(posedge clk);
        #1;
        core_valid_out = 1'b0;
        core_data_out  = 1'b0;
        core_finished  = !m_stall && (m_hdr_read == 10);
        if (!m_stall) begin
            if (core_enable && fifo_q.size() > 0) begin
                core_valid_out = 1'b1;
                core_data_out  = fifo_q.pop_front();
                m_hdr_read++;
            end else if (m_hdr_read == 10 && m_hec_sent < 8) begin
                core_valid_out = 1'b1;
                core_data_out  = m_hec_sh[7];
                exp_q.push_back(m_hec_sh[7]);
                m_hec_sh = m_hec_sh << 1;
                m_hec_sent++;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset(input logic stall, input logic [7:0] seed);
        m_stall        = stall;
        m_hec_sh       = seed;
        m_hdr_read     = 0;
        m_hec_sent     = 0;
        fifo_q.delete();
        exp_q.delete();
        core_finished  = 1'b0;
        core_valid_out = 1'b0;
        core_data_out  = 1'b0;
    endtask

    task automatic run_packet(input vec_t v, input int idx);
        int         s_ready, s_done, s_en, s_wr, s_acc;
        int         sent, k, guard;
        logic [9:0] sh;
        string      tag;
        tag = $sformatf("row%0d", idx);
        model_reset(v.stall, v.seed);
        core_num_after_hec = v.len17 ? 14'd17 : 14'd18;
        s_ready = n_ready; s_done = n_done; s_en = n_en; s_wr = n_wr; s_acc = n_acc;

        uap_dci_cfg = v.seed;
        start = 1'b1;
        tick();
        start = 1'b0;

        sh = v.hdr; sent = 0; k = 0;
        while (sent < 10 && k < 40) begin
            start = 1'b0;
            if (v.poke && k == 3) begin
                start       = 1'b1;
                uap_dci_cfg = 8'h12;
            end
            if (!v.toggle || (k % 2 == 0)) begin
                in_valid = 1'b1;
                in_data  = sh[9];
                exp_q.push_back(sh[9]);
                sh = sh << 1;
                sent++;
            end else begin
                in_valid = 1'b0;
                in_data  = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0; in_valid = 1'b0; in_data = 1'b0;

        guard = 0;
        while (busy && guard < 1300) begin
            tick();
            guard++;
        end
        check({tag, "_idle_reached"}, {31'd0, guard < 1300}, 32'd1);
        check({tag, "_in_ready_cycles"}, n_ready - s_ready, v.exp_ready);
        check({tag, "_accepted_bits"}, n_acc - s_acc, 32'd10);
        check({tag, "_core_writes"}, n_wr - s_wr, 32'd10);
        check({tag, "_enable_latency"}, first_en_cyc - last_acc_cyc, 32'd1);
        check({tag, "_enable_cycles"}, n_en - s_en, v.exp_en);
        check({tag, "_done_pulses"}, n_done - s_done, v.exp_done);
        check({tag, "_out_count"}, {23'd0, out_count}, v.exp_oc);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, v.exp_tmo});
        check({tag, "_seed"}, {24'd0, core_uap_dci}, {24'd0, v.seed});
        check({tag, "_enable_off"}, {31'd0, core_enable}, 32'd0);
        if (!v.stall)
            check({tag, "_sb_left"}, exp_q.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] seed, input logic [9:0] hdr,
                                input logic toggle, input logic stall, input logic poke,
                                input logic len17, input int exp_ready, input int exp_oc,
                                input int exp_done, input int exp_en, input logic exp_tmo);
        vec_t v;
        v.seed = seed; v.hdr = hdr; v.toggle = toggle; v.stall = stall;
        v.poke = poke; v.len17 = len17; v.exp_ready = exp_ready; v.exp_oc = exp_oc;
        v.exp_done = exp_done; v.exp_en = exp_en; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        //            seed   header         tog  stl  poke len  rdy oc  done en    tmo
        vecs[0] = mk(8'h47, 10'b1011001110, 1'b0, 1'b0, 1'b0, 1'b0, 10, 18, 1, 11,   1'b0);
        vecs[1] = mk(8'h5A, 10'b0100110001, 1'b1, 1'b0, 1'b0, 1'b0, 19, 18, 1, 11,   1'b0);
        vecs[2] = mk(8'h47, 10'b1110001011, 1'b0, 1'b0, 1'b1, 1'b0, 10, 18, 1, 11,   1'b0);
        vecs[3] = mk(8'h33, 10'b1011001110, 1'b0, 1'b1, 1'b0, 1'b0, 10, 0,  0, 1024, 1'b1);
        vecs[4] = mk(8'h6E, 10'b0000000001, 1'b0, 1'b0, 1'b0, 1'b1, 10, 18, 1, 11,   LEN_CHK);
        vecs[5] = mk(8'hC1, 10'b1111111111, 1'b0, 1'b0, 1'b0, 1'b0, 10, 18, 1, 11,   1'b0);

        reset = 1'b0; start = 1'b0; abort = 1'b0; uap_dci_cfg = 8'h00;
        in_valid = 1'b0; in_data = 1'b0; core_num_after_hec = 14'd18;
        model_reset(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_core_enable", {31'd0, core_enable}, 32'd0);
        check("reset_core_uap_dci", {24'd0, core_uap_dci}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("reset_out_count", {23'd0, out_count}, 32'd0);
        check("reset_misc", {28'd0, core_valid_in, core_data_in, out_valid, out_data}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 6; r++)
            run_packet(vecs[r], r);

        // abort in the middle of DRAIN with a stalled core
        model_reset(1'b1, 8'h3C);
        uap_dci_cfg = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = i[0];
            tick();
        end
        in_valid = 1'b0; in_data = 1'b0;
        repeat (5) tick();
        check("abort_pre_enable", {31'd0, core_enable}, 32'd1);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_enable", {31'd0, core_enable}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("abort_seed_held", {24'd0, core_uap_dci}, 32'h3C);

        // abort beats a simultaneous start in IDLE
        abort = 1'b1; start = 1'b1; uap_dci_cfg = 8'h99;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        check("abort_start_seed", {24'd0, core_uap_dci}, 32'h3C);
        repeat (2) tick();
        check("abort_start_still_idle", {31'd0, busy}, 32'd0);

        // fresh packet after abort picks up the new seed
        run_packet(mk(8'hA5, 10'b1011001110, 1'b0, 1'b0, 1'b0, 1'b0, 10, 18, 1, 11, 1'b0), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ble_hec_tx_sequencer.md
Name: ble_hec_tx_sequencer

Overview:
- Controller for the Bluetooth TX header path, which is the bit FIFO plus HEC generator core.
- Accepts one packet header at a time from the link-layer side and gates header bits into the core's write port.
- Drives the core's read enable to drain the FIFO through the HEC, counts the header+HEC bits the core emits, and reports done, or a timeout if the core stalls.
- Latches the UAP/DCI seed per packet so the core's seed stays stable for the whole packet.

Parameters:
- HDR_BITS, 10, header bits per packet accepted from upstream (1..255).
- HEC_BITS, 8, HEC bits appended by the core.
- TIMEOUT, 1023, max cycles in DRAIN+FLUSH before error (counter width 10).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a packet; ignored unless IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- uap_dci_cfg  in  8  seed; sampled on accepted start
- in_valid  in  1  upstream header bit valid
- in_data  in  1  upstream header bit
- in_ready  out  1  sequencer accepts a bit this cycle
- core_valid_in  out  1  to core write strobe
- core_data_in  out  1  to core data bit
- core_enable  out  1  to core FIFO read enable
- core_uap_dci  out  8  latched seed to core
- core_finished  in  1  core FIFO empty/drained indication
- core_valid_out  in  1  core output bit valid
- core_data_out  in  1  core output bit
- core_num_after_hec  in  14  core bit count (used only with optional feature)
- out_valid  out  1  forwarded output bit valid
- out_data  out  1  forwarded output bit
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on packet completion
- timeout_err  out  1  sticky; cleared by next accepted start
- out_count  out  9  bits forwarded in the current packet

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All outputs 0: in_ready, core_valid_in, core_data_in, core_enable, core_uap_dci=8'h00, out_valid, out_data, busy, done, timeout_err, out_count=0.
  - Internal wr_cnt=0, tmo_cnt=0.
- States: IDLE, FILL, DRAIN, FLUSH, DONE, ERR.
- IDLE:
  - start=1 latches uap_dci_cfg into core_uap_dci, clears wr_cnt, out_count, tmo_cnt and timeout_err, then moves to FILL.
- FILL:
  - in_ready=1 (combinational from state).
  - core_valid_in = in_valid & in_ready; core_data_in = in_data (combinational, zero latency into the core).
  - Each accepted bit increments wr_cnt.
  - On the accepted bit with wr_cnt==HDR_BITS-1, go to DRAIN; in_ready is 0 from the next cycle.
- DRAIN:
  - core_enable=1 (registered, asserted the cycle after entry).
  - tmo_cnt increments each cycle.
  - core_finished=1 drops core_enable the next cycle and moves to FLUSH.
- FLUSH:
  - core_enable=0; keep counting output bits.
  - When out_count==HDR_BITS+HEC_BITS, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy is still 1 in DONE.
- ERR:
  - Entered from DRAIN or FLUSH when tmo_cnt==TIMEOUT.
  - Sets timeout_err; core_enable=0; returns to IDLE the next cycle.
  - No done pulse.
- Output forwarding, in states FILL..DONE:
  - out_valid = core_valid_out; out_data = core_data_out (combinational).
  - out_count increments on each core_valid_out, saturating at 511.
  - In IDLE/ERR, out_valid=0 and core bits are dropped.
- Output completion vs. core_finished:
  - If out_count reaches HDR_BITS+HEC_BITS while still in DRAIN, the transition to FLUSH occurs normally and DONE follows immediately.
  - Completion has priority over timeout in the same cycle.
- abort:
  - Next cycle: IDLE, core_enable=0, in_ready=0.
  - Counters hold their values until the next start; timeout_err is unchanged.
  - abort has priority over start and all transitions.
- start while busy: ignored, no effect on the latched seed.

Optional Feature:
- Macro BLE_HEC_SEQ_LEN_CHECK_EN.
- Defined:
  - On the cycle entering DONE, compare core_num_after_hec against HDR_BITS+HEC_BITS.
  - Mismatch sets a sticky internal len_err, visible as timeout_err OR len_err on timeout_err.
  - len_err is cleared on the next accepted start.
- Undefined:
  - core_num_after_hec is unused and only timeouts set timeout_err.

Test Plan:
- Seed 0x47, start, then 10 header bits 1011001110 with in_valid continuous, core model emitting 18 bits → in_ready high for exactly 10 cycles; core_enable asserted the cycle after bit 10; done pulses once; out_count=18; timeout_err=0.
- in_valid toggling 1/0 during FILL → wr_cnt advances only on valid cycles; DRAIN entered only after the 10th valid bit.
- Core never asserts core_finished → timeout_err=1 after 1023 cycles in DRAIN; core_enable=0; state IDLE; no done pulse.
- abort asserted mid-DRAIN → core_enable=0 the next cycle, busy=0; a following start with seed 0xA5 gives core_uap_dci=0xA5.
- start pulsed at 0x12 while in FILL with seed 0x47 → ignored; core_uap_dci stays 0x47; packet completes normally.
- With BLE_HEC_SEQ_LEN_CHECK_EN, core_num_after_hec=17 at DONE → timeout_err=1 after the done pulse; without the macro → timeout_err=0.
